decode_stage: RTL

//  MIPS ID stage: control decode, register file (2R/1W), sign-extend/shift, ID/EX pipeline register.

---
 rtl/decode_pkg.sv | 37 +++
 rtl/regfile_mp.sv | 30 +++
 rtl/decode_stage.sv | 68 ++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU op encodings, control bundle and the opcode decoder shared by the ID stage
package decode_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam int CTRL_W         = 9;
  localparam int CTRL_REG_DST   = 8;
  localparam int CTRL_BRANCH    = 7;
  localparam int CTRL_MEM_READ  = 6;
  localparam int CTRL_REG_WRITE = 0;
  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '0;
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    return op == OP_R    ? ctrl_t'({1'b1, 3'b000, ALU_FUNCT, 3'b001}) :
           op == OP_LW   ? ctrl_t'({1'b0, 3'b011, ALU_ADD,   3'b011}) :
           op == OP_SW   ? ctrl_t'({1'b0, 3'b000, ALU_ADD,   3'b110}) :
           op == OP_BEQ  ? ctrl_t'({1'b0, 3'b100, ALU_SUB,   3'b000}) :
           op == OP_ADDI ? ctrl_t'({1'b0, 3'b000, ALU_ADD,   3'b011}) : CTRL_NOP;
  endfunction
  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_R || op == OP_SW || op == OP_BEQ;
  endfunction
endpackage

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/1-write register file, r0 hardwired to zero, optional write-through bypass (DECODE_BYPASS_EN); ports clk, reset (async active-low), ra/rb read address+data, we/wa/wd write
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
`ifdef DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic wr;
  assign wr = we && wa != '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) regs <= '{default: '0};
    else if (wr) regs[wa] <= wd;
  assign ra_data = ra_addr == '0 ? '0 : (BYPASS && wr && wa == ra_addr) ? wd : regs[ra_addr];
  assign rb_data = rb_addr == '0 ? '0 : (BYPASS && wr && wa == rb_addr) ? wd : regs[rb_addr];
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage (decoder, regfile, immediates, load-use hazard stall, ID/EX register with valid/ready and flush); clk, reset (async active-low), if_* from fetch, id_*/ex_ready to execute, wb_* write-back; DECODE_BYPASS_EN enables regfile write-through
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int IMM_W = 16,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [31:0]       if_instr,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imm_sx,
  output logic [DATA_W-1:0] id_imm_sx_sh,
  output logic [ADDR_W-1:0] id_dest,
  output logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [5:0] op;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_data, rt_data, imm_sx;
  ctrl_t dec_ctrl, ctrl_q;
  logic haz, accept;
  assign op = if_instr[31:26];
  assign rs = ADDR_W'(if_instr[25:21]);
  assign rt = ADDR_W'(if_instr[20:16]);
  assign rd = ADDR_W'(if_instr[15:11]);
  assign dec_ctrl = decode_ctrl(op);
  assign imm_sx = DATA_W'($signed(if_instr[IMM_W-1:0]));
  regfile_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .reset(reset),
    .ra_addr(rs), .rb_addr(rt), .ra_data(rs_data), .rb_data(rt_data),
    .we(wb_en), .wa(wb_addr), .wd(wb_data)
  );
  // A load in ID/EX cannot forward its data yet, so any consumer of its destination waits one cycle
  assign haz = id_valid && ctrl_q.mem_read && id_dest != '0 &&
               (id_dest == rs || (id_dest == rt && reads_rt(op)));
  assign if_ready = (!id_valid || ex_ready) && !haz;
  assign accept = if_valid && if_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      id_valid   <= 1'b0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm_sx  <= '0;
      id_dest    <= '0;
      ctrl_q     <= CTRL_NOP;
    end else if (flush) id_valid <= 1'b0;
    else if (accept) begin
      id_valid   <= 1'b1;
      id_rs_data <= rs_data;
      id_rt_data <= rt_data;
      id_imm_sx  <= imm_sx;
      id_dest    <= dec_ctrl.reg_dst ? rd : rt;
      ctrl_q     <= dec_ctrl;
    end else if (id_valid && ex_ready) id_valid <= 1'b0;
  assign id_ctrl = ctrl_q;
  assign id_imm_sx_sh = id_imm_sx << 2;
endmodule
